// File: rtl/amm_slave_responder_pkg.sv
// Shared types and limits for the Avalon-MM slave responder.
//   state_t       : command FSM states
//   DATA_W / BE_W : bus data width and byte-lane count
//   *_MIN / *_MAX : legal ranges for the wait-state and read-latency parameters
//   be_merge()    : byte-lane merge used by the memory write path
package amm_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCEPT = 2'd2
  } state_t;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam int WAIT_STATES_MIN  = 0;
  localparam int WAIT_STATES_MAX  = 15;
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  // Lanes with be[i]=1 take the new byte, the rest keep the old one.
  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_word,
                                                 input logic [DATA_W-1:0] new_word,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/amm_slave_responder_if.sv
// Avalon-MM bus between the user master and the slave responder.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives waitrequest/readdata/readdatavalid
//   slave modport  : the mirror image
interface amm_slave_responder_if
  import amm_slave_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [BE_W-1:0]   avs_byteenable;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );

endinterface

// File: rtl/amm_slave_responder_rd_pipe.sv
// Fixed-latency read return pipeline: DEPTH stages of {valid, data}.
//   clk, rst_n          : clock, async active-low clear (flushes in-flight reads)
//   in_valid, in_data   : read accepted this cycle and the word fetched for it
//   out_valid, out_data : response DEPTH cycles later
module amm_rd_pipe #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/amm_slave_responder.sv
// Avalon-MM slave standing in for SDRAM during master bring-up: word-addressed
// memory with byteenable writes, programmable wait states, fixed read latency.
//   clk, reset_n  : system clock, async active-low reset
//   avs           : Avalon-MM slave bus (interface, slave modport)
//   wr_count      : accepted writes, wraps
//   rd_count      : accepted reads, wraps
//   protocol_err  : sticky; set on read+write together or a command dropped in WAIT
//
// state  | meaning
// IDLE   | no command pending; with WAIT_STATES=0 commands accept here directly,
//        | otherwise this cycle is the first stall cycle of a new command
// WAIT   | further stall cycles, wait_cnt counts stall cycles served so far
// ACCEPT | waitrequest low for one cycle, command executes
module amm_slave_responder
  import amm_slave_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int WAIT_STATES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  amm_slave_responder_if.slave avs,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count,
  output logic                 protocol_err
);

  if (WAIT_STATES < WAIT_STATES_MIN || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_ws
    $error("amm_slave_responder: WAIT_STATES out of range 0..15");
  end
  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_rl
    $error("amm_slave_responder: READ_LATENCY out of range 1..4");
  end

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  // Two-flop release stage: waitrequest cannot drop before the second edge
  // after reset_n rises.
  logic rst_meta, rst_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta  <= 1'b0;
      rst_ready <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_ready <= rst_meta;
    end
  end

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       waitreq;
  logic       drop_err;
  logic       cmd;

  assign cmd = avs.avs_read | avs.avs_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The IDLE cycle that first sees a command already counts as stall cycle 1,
  // so a command costs WAIT_STATES stall cycles plus the ACCEPT cycle.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    waitreq  = 1'b1;
    drop_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst_ready) begin
          waitreq = 1'b1;
        end else if (WAIT_STATES == 0) begin
          waitreq = 1'b0;
        end else if (cmd) begin
          wait_d  = 4'd1;
          state_d = (WS_CNT == 4'd1) ? ACCEPT : WAIT;
        end
      end
      WAIT: begin
        if (!cmd) begin
          drop_err = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
          if (wait_d == WS_CNT) state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        waitreq = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic accept, wr_acc, rd_acc, both_err;

  assign accept   = cmd & ~waitreq;
  assign wr_acc   = accept & avs.avs_write;
  assign rd_acc   = accept & avs.avs_read & ~avs.avs_write;
  assign both_err = accept & avs.avs_read & avs.avs_write;

  // Memory is deliberately not reset so contents survive a reset pulse.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[avs.avs_address] <= be_merge(mem[avs.avs_address], avs.avs_writedata,
                                       avs.avs_byteenable);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count     <= '0;
      rd_count     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (wr_acc) wr_count <= wr_count + 16'd1;
      if (rd_acc) rd_count <= rd_count + 16'd1;
      if (drop_err || both_err) protocol_err <= 1'b1;
    end
  end

  // Combinational fetch at accept: a write accepted in the previous cycle is
  // already in the array, giving write-first ordering.
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  amm_rd_pipe #(
    .DEPTH  (READ_LATENCY),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (reset_n),
    .in_valid  (rd_acc),
    .in_data   (mem[avs.avs_address]),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

  assign avs.avs_waitrequest   = waitreq;
  assign avs.avs_readdatavalid = rd_valid;
  assign avs.avs_readdata      = rd_data;

endmodule

// File: tb/tb_amm_slave_responder.sv
// Bench for amm_slave_responder: dut_a (WAIT_STATES=1, READ_LATENCY=2) and
// dut_b (WAIT_STATES=0, READ_LATENCY=2). Read responses are checked by
// per-DUT scoreboards fed at read accept.
module tb_amm_slave_responder;
  import amm_slave_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [15:0] wr_a, rd_a, wr_b, rd_b;
  logic        err_a, err_b;

  amm_slave_responder_if #(.ADDR_W(8)) bus_a ();
  amm_slave_responder_if #(.ADDR_W(8)) bus_b ();

  amm_slave_responder #(.ADDR_W(8), .WAIT_STATES(1), .READ_LATENCY(2)) dut_a (
    .clk(clk), .reset_n(rst_a), .avs(bus_a),
    .wr_count(wr_a), .rd_count(rd_a), .protocol_err(err_a)
  );

  amm_slave_responder #(.ADDR_W(8), .WAIT_STATES(0), .READ_LATENCY(2)) dut_b (
    .clk(clk), .reset_n(rst_b), .avs(bus_b),
    .wr_count(wr_b), .rd_count(rd_b), .protocol_err(err_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (bus_a.avs_readdatavalid !== 1'b0) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_rdv", {31'd0, bus_a.avs_readdatavalid}, 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("a_rdata", bus_a.avs_readdata, e.data);
        chk("a_rdv_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (bus_b.avs_readdatavalid !== 1'b0) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_rdv", {31'd0, bus_b.avs_readdatavalid}, 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("b_rdata", bus_b.avs_readdata, e.data);
        chk("b_rdv_cycle", cyc, e.due);
      end
    end
  end

  // Issue one command on bus_a and hold it until accepted; returns stall count.
  task automatic a_cmd(input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [3:0] be,
                       input bit expect_rsp, input logic [31:0] exp_rd,
                       output int stalls);
    bit   done;
    exp_t e;
    done   = 1'b0;
    stalls = 0;
    bus_a.avs_address    = addr;
    bus_a.avs_writedata  = data;
    bus_a.avs_byteenable = be;
    bus_a.avs_read       = rd;
    bus_a.avs_write      = wr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus_a.avs_waitrequest) begin
        stalls++;
      end else begin
        done = 1'b1;
        if (expect_rsp) begin
          e.data = exp_rd;
          e.due  = cyc + 2;
          q_a.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    bus_a.avs_read  = 1'b0;
    bus_a.avs_write = 1'b0;
    if (!done) chk("a_cmd_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st;
    exp_t e;

    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.avs_address = '0; bus_a.avs_read = 1'b0; bus_a.avs_write = 1'b0;
    bus_a.avs_writedata = '0; bus_a.avs_byteenable = '0;
    bus_b.avs_address = '0; bus_b.avs_read = 1'b0; bus_b.avs_write = 1'b0;
    bus_b.avs_writedata = '0; bus_b.avs_byteenable = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_waitreq", {31'd0, bus_a.avs_waitrequest}, 32'd1);
    chk("rst_rdv", {31'd0, bus_a.avs_readdatavalid}, 32'd0);
    chk("rst_rdata", bus_a.avs_readdata, 32'd0);
    chk("rst_wr_count", {16'd0, wr_a}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);

    // Release; waitrequest on the zero-wait DUT must drop only after edge 2
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_wreq_before_edge1", {31'd0, bus_b.avs_waitrequest}, 32'd1);
    @(negedge clk);
    chk("b_wreq_after_edge1", {31'd0, bus_b.avs_waitrequest}, 32'd1);
    @(negedge clk);
    chk("b_wreq_after_edge2", {31'd0, bus_b.avs_waitrequest}, 32'd0);
    @(posedge clk);
    #1;

    // Basic write then read
    a_cmd(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, st);
    chk("a_wr_stalls", st, 32'd1);
    a_cmd(1'b1, 1'b0, 8'h05, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, st);
    chk("a_rd_stalls", st, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("a_wr_count_1", {16'd0, wr_a}, 32'd1);
    chk("a_rd_count_1", {16'd0, rd_a}, 32'd1);

    // Byte enables
    a_cmd(1'b0, 1'b1, 8'h10, 32'h11223344, 4'b1111, 1'b0, 32'h0, st);
    a_cmd(1'b0, 1'b1, 8'h10, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, st);
    a_cmd(1'b1, 1'b0, 8'h10, 32'h0, 4'hF, 1'b1, 32'h11BB33DD, st);
    a_cmd(1'b0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, st);
    a_cmd(1'b1, 1'b0, 8'h10, 32'h0, 4'hF, 1'b1, 32'h11BB33DD, st);
    repeat (4) @(posedge clk);
    #1;
    chk("a_wr_count_be0", {16'd0, wr_a}, 32'd4);
    chk("a_rd_count_3", {16'd0, rd_a}, 32'd3);
    chk("a_err_clean", {31'd0, err_a}, 32'd0);

    // Simultaneous read and write: write only, flagged
    a_cmd(1'b1, 1'b1, 8'h20, 32'h00000055, 4'hF, 1'b0, 32'h0, st);
    repeat (4) @(posedge clk);
    #1;
    chk("a_both_err", {31'd0, err_a}, 32'd1);
    chk("a_both_rd_count", {16'd0, rd_a}, 32'd3);
    chk("a_both_wr_count", {16'd0, wr_a}, 32'd5);
    a_cmd(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 1'b1, 32'h00000055, st);
    repeat (4) @(posedge clk);
    #1;
    chk("a_q_drain_1", q_a.size(), 32'd0);

    // Reset one cycle after a read accept: the response must never appear
    a_cmd(1'b1, 1'b0, 8'h05, 32'h0, 4'hF, 1'b0, 32'h0, st);
    rst_a = 1'b0;
    @(negedge clk);
    chk("a_midrst_waitreq", {31'd0, bus_a.avs_waitrequest}, 32'd1);
    chk("a_midrst_wr_count", {16'd0, wr_a}, 32'd0);
    chk("a_midrst_rd_count", {16'd0, rd_a}, 32'd0);
    chk("a_midrst_err", {31'd0, err_a}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    a_cmd(1'b1, 1'b0, 8'h05, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, st);
    repeat (4) @(posedge clk);
    #1;
    chk("a_q_drain_2", q_a.size(), 32'd0);
    chk("a_post_rst_rd_count", {16'd0, rd_a}, 32'd1);

    // Zero wait states: preload then four back-to-back reads
    bus_b.avs_byteenable = 4'hF;
    bus_b.avs_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_b.avs_address   = 8'(i);
      bus_b.avs_writedata = 32'h000000A0 + 32'(i);
      @(negedge clk);
      chk("b_wr_waitreq", {31'd0, bus_b.avs_waitrequest}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus_b.avs_write = 1'b0;
    bus_b.avs_read  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_b.avs_address = 8'(i);
      @(negedge clk);
      chk("b_rd_waitreq", {31'd0, bus_b.avs_waitrequest}, 32'd0);
      e.data = 32'h000000A0 + 32'(i);
      e.due  = cyc + 2;
      q_b.push_back(e);
      @(posedge clk);
      #1;
    end
    bus_b.avs_read = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b_q_drain", q_b.size(), 32'd0);
    chk("b_rd_count", {16'd0, rd_b}, 32'd4);
    chk("b_wr_count", {16'd0, wr_b}, 32'd4);

    // Write counter wrap
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_b.avs_address   = 8'h30;
    bus_b.avs_writedata = 32'h12345678;
    bus_b.avs_write     = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    @(negedge clk);
    chk("b_wr_count_ffff", {16'd0, wr_b}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    bus_b.avs_write = 1'b0;
    @(negedge clk);
    chk("b_wr_count_wrap", {16'd0, wr_b}, 32'h00000000);
    chk("b_wrap_err", {31'd0, err_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amm_slave_responder.md
Name: amm_slave_responder

Overview:
- Avalon-MM slave that services the user module's Avalon-MM master, which drives read/write with a 28-bit address.
- Holds a word-addressed on-chip memory with byteenable writes, programmable wait states and a fixed pipelined read latency.
- Exports access counters and a sticky protocol-error flag for the debug conduit.
- Sits inside the Qsys system in place of SDRAM during bring-up and bench testing of the master.

Parameters:
- ADDR_W, 8, word-address width; memory depth = 2**ADDR_W words of 32 bits.
- WAIT_STATES, 1, waitrequest cycles inserted before each command is accepted; legal range 0..15.
- READ_LATENCY, 2, cycles from read accept to readdatavalid; legal range 1..4.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- avs_address, in, ADDR_W, word address.
- avs_read, in, 1, read request.
- avs_write, in, 1, write request.
- avs_writedata, in, 32, write data.
- avs_byteenable, in, 4, byte lane enables; bit i enables bits 8i+7..8i.
- avs_waitrequest, out, 1, stall; a command is accepted in a cycle with (read|write) && !waitrequest.
- avs_readdata, out, 32, read data, valid only when readdatavalid is high.
- avs_readdatavalid, out, 1, one-cycle pulse per accepted read.
- wr_count, out, 16, accepted writes; wraps 0xFFFF->0x0000.
- rd_count, out, 16, accepted reads; wraps.
- protocol_err, out, 1, sticky violation flag; cleared only by reset.

Behaviour:
- Reset: async assert of reset_n.
  - avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, counters=0, protocol_err=0.
  - Read pipeline flushed and FSM to IDLE; memory contents are not reset.
  - Reset mid-operation: an in-flight read never produces readdatavalid.
- FSM states: IDLE, WAIT, ACCEPT.
  - IDLE: waitrequest = (WAIT_STATES!=0).
    - WAIT_STATES=0: commands accept directly in IDLE.
    - Otherwise a command moves the FSM to WAIT and loads wait_cnt=1.
  - WAIT: waitrequest=1. wait_cnt increments. At wait_cnt==WAIT_STATES go to ACCEPT.
    - If read and write both drop in WAIT: set protocol_err, return IDLE, no access.
  - ACCEPT: waitrequest=0 for exactly one cycle. Command executes, then back to IDLE.
    - Back-to-back commands therefore cost WAIT_STATES+1 cycles each.
- First deassertion of waitrequest after reset release is on the second clk edge; this is a reset synchroniser stage.
- Write: on accept, mem[address] lanes with byteenable=1 are updated; other lanes are held. wr_count++.
  - byteenable=0000 still counts but changes nothing.
- Read: on accept (cycle N), the address enters a READ_LATENCY-deep valid/data pipeline. rd_count++.
  - readdatavalid=1 in cycle N+READ_LATENCY, with readdata=mem[address].
  - The value returned is the memory content after all writes accepted before cycle N; write-first, so a write accepted at N-1 is visible.
  - Up to READ_LATENCY reads may be outstanding. Responses return in order, with no bubbles beyond command spacing.
- Simultaneous read and write: treated as a write only; the read is dropped, protocol_err is set, rd_count is unchanged.
- Commands presented while waitrequest=1 must be held stable by the master. The slave does not check stability except for the drop case in WAIT.
- Counter overflow wraps silently, with no error.

Decomposition:
- Package amm_slave_pkg holds:
  - state enum (IDLE, WAIT, ACCEPT);
  - DATA_W=32 and BE_W=4 constants;
  - the legal-range limits for WAIT_STATES and READ_LATENCY, checked by elaboration assertions.
- One sub-module, amm_rd_pipe: READ_LATENCY-stage shift register of {valid, data}, with its own async clear.
- The memory array, byte-lane write logic, FSM and counters stay in the top module.

Test Plan:
- WAIT_STATES=1, READ_LATENCY=2; write 0xDEADBEEF to addr 0x05 with be=1111, then read 0x05.
  - waitrequest is high for 1 cycle per command.
  - readdatavalid comes 2 cycles after read accept with 0xDEADBEEF.
  - wr_count=1, rd_count=1.
- Byteenable: write 0x11223344 with be=1111, then 0xAABBCCDD with be=0101 to addr 0x10, then read -> 0x11BB33DD.
- WAIT_STATES=0: four back-to-back reads to addrs 0..3, preloaded 0xA0..0xA3.
  - waitrequest stays 0.
  - readdatavalid is high for 4 consecutive cycles, in order.
- Read and write both high at addr 0x20 with data 0x55: memory is written, no readdatavalid, protocol_err=1, rd_count unchanged.
- Reset mid-read: assert reset_n low 1 cycle after a read accept.
  - No readdatavalid ever appears.
  - Counters are 0 and waitrequest=1 during reset.
  - Memory value at the read address is preserved on a later read.
- Counter wrap: issue 65536 writes -> wr_count=0x0000 and protocol_err=0.
